// File: rtl/w_mem_reader_pkg.sv
// Shared types and constants for the weight-memory read sequencer.
package w_mem_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } rd_state_t;

   localparam int unsigned W_RD_FIFO_DEPTH = 2;

endpackage

// File: rtl/w_rd_fifo.sv
// Small synchronous FIFO that absorbs the weight-memory read latency.
module w_rd_fifo
   import w_mem_reader_pkg::*;
#(
   parameter int dataWidth = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [dataWidth-1:0] wdata,
   output logic [dataWidth-1:0] rdata,
   output logic                 full,
   output logic                 empty,
   output logic [1:0]           count
);

   localparam int unsigned PW = $clog2(W_RD_FIFO_DEPTH);

   logic [dataWidth-1:0] mem [W_RD_FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [1:0]           cnt;
   logic                 do_pop;

   // Status flags and head of queue.
   always_comb begin
      empty  = (cnt == 2'd0);
      full   = (cnt == 2'(W_RD_FIFO_DEPTH));
      count  = cnt;
      rdata  = mem[rd_ptr];
      do_pop = pop && !empty;
   end

   // Storage, pointers and occupancy; push and pop may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < W_RD_FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/w_mem_reader.sv
// Walks the weight memory and streams weights to the MAC over valid/ready.
module w_mem_reader
   import w_mem_reader_pkg::*;
#(
   parameter int numWeight    = 10,
   parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
   parameter int dataWidth    = 16,
   parameter int cntWidth     = $clog2(numWeight + 1)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    mem_ren,
   output logic [addressWidth-1:0] mem_radd,
   input  logic [dataWidth-1:0]    mem_rdata,
   output logic                    w_valid,
   input  logic                    w_ready,
   output logic [dataWidth-1:0]    w_data,
   output logic                    w_last
);

   localparam logic [cntWidth-1:0] N_CNT    = cntWidth'(numWeight);
   localparam logic [cntWidth-1:0] LAST_IDX = cntWidth'(numWeight - 1);

   rd_state_t             state;
   rd_state_t             state_nxt;
   logic [cntWidth-1:0]     issue_cnt;
   logic [cntWidth-1:0]     out_cnt;
   logic                    rd_pending;
   logic [addressWidth-1:0] radd_q;
   logic                    pop;
   logic                    issue;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [1:0]              fifo_count;
   logic [2:0]              credit_used;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and status outputs; busy covers the done cycle too.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (pop && w_last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Credit-based issue: in-flight read plus buffered entries, less this
   // cycle's pop, must leave room in the 2-entry buffer.
   always_comb begin
      w_valid     = !fifo_empty;
      pop         = w_valid && w_ready;
      w_last      = w_valid && (out_cnt == LAST_IDX);
      credit_used = {2'b00, rd_pending} + {1'b0, fifo_count};
      issue       = (state == RUN) && (issue_cnt < N_CNT) &&
                    (credit_used < (3'd2 + {2'b00, pop}));
      mem_ren     = issue;
      mem_radd    = issue ? issue_cnt[addressWidth-1:0] : radd_q;
   end

   // Issue/output counters, read-return tracking and held read address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt  <= '0;
         out_cnt    <= '0;
         rd_pending <= 1'b0;
         radd_q     <= '0;
      end else begin
         rd_pending <= issue;
         if (issue) radd_q <= issue_cnt[addressWidth-1:0];
         if (state == IDLE && start) begin
            issue_cnt <= '0;
            out_cnt   <= '0;
         end else begin
            if (issue) issue_cnt <= issue_cnt + cntWidth'(1);
            if (pop)   out_cnt   <= out_cnt + cntWidth'(1);
         end
      end
   end

   w_rd_fifo #(
      .dataWidth(dataWidth)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_pending),
      .pop   (pop),
      .wdata (mem_rdata),
      .rdata (w_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A returning read must always find a free slot.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_pending && fifo_full && !pop));

endmodule

// File: tb/tb_w_mem_reader.sv
// Directed bench for w_mem_reader: a 10-weight build and a 1-weight build.
module tb_w_mem_reader;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start, busy, done, mem_ren, w_valid, w_ready, w_last;
   logic [3:0]  mem_radd;
   logic [15:0] mem_rdata, w_data;

   logic        start1, busy1, done1, mem_ren1, w_valid1, w_ready1, w_last1;
   logic [0:0]  mem_radd1;
   logic [15:0] mem_rdata1, w_data1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   w_mem_reader #(.numWeight(10), .dataWidth(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
   );

   w_mem_reader #(.numWeight(1), .dataWidth(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .mem_ren(mem_ren1), .mem_radd(mem_radd1), .mem_rdata(mem_rdata1),
      .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1), .w_last(w_last1)
   );

   // Weight memories: mem[i] = 16'h1000 + i, one-cycle registered read.
   always @(posedge clk) begin
      if (mem_ren)  mem_rdata  <= 16'h1000 + 16'(mem_radd);
      if (mem_ren1) mem_rdata1 <= 16'h1000 + 16'(mem_radd1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: ready always high; 1: ready high on even cycles; 2: ready low until cycle 21.
   task automatic run_pass(input int mode, input bit restart, input int exp_done);
      int          pops, dones, issued, done_cyc, ren_early;
      logic [15:0] hold_d;
      logic        hold_l, hold_v;
      pops = 0; dones = 0; issued = 0; done_cyc = -1; ren_early = 0;
      hold_v = 1'b0; hold_d = '0; hold_l = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         start = (cyc == 0) || (restart && cyc == 5);
         case (mode)
            0:       w_ready = 1'b1;
            1:       w_ready = (cyc % 2 == 0);
            default: w_ready = (cyc > 20);
         endcase
         @(negedge clk);
         if (hold_v)
            check("stall_hold", {w_valid, w_last, w_data}, {1'b1, hold_l, hold_d});
         hold_v = w_valid && !w_ready;
         hold_d = w_data;
         hold_l = w_last;
         check("busy", busy, (cyc >= 1) && (dones == 0));
         if (mem_ren) begin
            check("radd", mem_radd, issued);
            issued++;
            if (mode == 2 && cyc <= 20) ren_early++;
         end
         if (w_valid && w_ready) begin
            check("data", w_data, 16'h1000 + pops);
            check("last", w_last, pops == 9);
            if (mode == 0) check("pop_cycle", cyc, 3 + pops);
            pops++;
         end
         check("ahead", (issued - pops) <= 2, 1);
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
         if (dones > 0 && cyc >= done_cyc + 2) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("n_weights", pops, 10);
      check("n_done", dones, 1);
      check("n_issued", issued, 10);
      check("done_cycle", done_cyc, exp_done);
      if (mode == 2) check("early_reads", ren_early, 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pops1, iss1, done_c;
      rst_n = 1'b0; start = 1'b0; w_ready = 1'b0; start1 = 1'b0; w_ready1 = 1'b0;
      #12;
      check("rst_out", {busy, done, mem_ren, mem_radd, w_valid, w_data, w_last}, '0);
      check("rst_out1", {busy1, done1, mem_ren1, w_valid1, w_data1, w_last1}, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_pass(0, 1'b0, 13);
      run_pass(0, 1'b1, 13);
      run_pass(0, 1'b0, 13);
      run_pass(1, 1'b0, 23);
      run_pass(2, 1'b0, 31);

      // Reset in cycle 6 of a pass.
      w_ready = 1'b1;
      start   = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 5) check("pre_rst_valid", w_valid, 1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("async_rst", {busy, done, mem_ren, mem_radd, w_valid, w_data, w_last}, '0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_hold", {busy, done, w_valid}, 3'b000);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_idle", {done, mem_ren, w_valid}, 3'b000);
         @(posedge clk); #1;
      end
      run_pass(0, 1'b0, 13);

      // Single-weight build.
      pops1 = 0; iss1 = 0; done_c = -1;
      start1 = 1'b1; w_ready1 = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         @(negedge clk);
         check("n1_busy", busy1, (cyc >= 1) && (cyc <= 4));
         if (mem_ren1) begin
            check("n1_radd", mem_radd1, 0);
            iss1++;
         end
         if (w_valid1) begin
            check("n1_data", w_data1, 16'h1000);
            check("n1_last", w_last1, 1);
            check("n1_cycle", cyc, 3);
            pops1++;
         end
         if (done1) done_c = cyc;
         @(posedge clk); #1;
         start1 = 1'b0;
      end
      check("n1_weights", pops1, 1);
      check("n1_issued", iss1, 1);
      check("n1_done_cycle", done_c, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/w_mem_reader.md
Name: w_mem_reader

Overview:
- Read-side sequencer for the per-neuron weight memories. These have a `ren`/`radd` read port with 1-cycle registered read data, and the data output holds its value when `ren` is low.
- On a `start` pulse, the block walks addresses 0..numWeight-1, absorbs the memory read latency in a 2-entry buffer, and streams the weights to the neuron MAC over a valid/ready interface, with `w_last` on the final weight.

Parameters:
- numWeight, 10, number of weights to fetch per pass (≥1)
- addressWidth, $clog2(numWeight), width of mem_radd
- dataWidth, 16, weight width (Q-format is opaque to this block)
- cntWidth, $clog2(numWeight+1), width of internal issue/output counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a pass when idle
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when the pass completes
- mem_ren  out  1  memory read enable
- mem_radd  out  addressWidth  memory read address
- mem_rdata  in  dataWidth  memory read data; valid one cycle after mem_ren
- w_valid  out  1  weight available
- w_ready  in  1  MAC accepts weight
- w_data  out  dataWidth  weight value
- w_last  out  1  high with the final weight (index numWeight-1)

Behaviour:
- Reset: all outputs 0 (busy, done, mem_ren, mem_radd, w_valid, w_data, w_last). Counters, buffer and FSM are cleared. Reset mid-pass abandons the pass with no done pulse; any in-flight read is discarded.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> DONE when the w_last handshake occurs (w_valid & w_ready & w_last).
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
  - busy=1 in RUN.
  - start is ignored in RUN and DONE.
- Issue: in RUN, mem_ren=1 when issue_cnt < numWeight and (outstanding + occupancy − pop) < 2.
  - pop = w_valid & w_ready this cycle.
  - outstanding = 1 if mem_ren was high in the previous cycle.
  - mem_radd = issue_cnt (truncated to addressWidth); issue_cnt increments on each issue.
  - mem_ren and mem_radd are combinational from registered state; mem_radd holds its last value when mem_ren=0.
- Return: a read issued in cycle t gives mem_rdata in cycle t+1, which is pushed into the 2-entry FIFO at the end of t+1. The credit rule guarantees the FIFO never overflows; push into a full FIFO is a design error (assert).
- Output:
  - w_valid = FIFO not empty; w_data = FIFO head.
  - w_last = (out_cnt == numWeight-1) & w_valid.
  - out_cnt increments on pop.
  - Simultaneous push and pop when the FIFO holds 1 entry: occupancy stays 1 and order is preserved.
- Latency (start sampled in cycle 0):
  - First mem_ren in cycle 1.
  - w_valid first high in cycle 3.
  - With w_ready held high, one weight per cycle: cycles 3..numWeight+2, then done in cycle numWeight+3.
- Backpressure: w_data and w_last are stable while w_valid & !w_ready. Issue stalls once 2 entries are in flight or buffered, and resumes in the cycle the MAC pops.
- Boundaries:
  - numWeight=1: single weight with w_last=1.
  - numWeight a power of 2: counters are cntWidth wide, so no wrap before completion.
  - No reads are issued after issue_cnt==numWeight.

Decomposition:
- Shared package: state enum (IDLE/RUN/DONE) typedef; FIFO depth constant W_RD_FIFO_DEPTH=2.
- One sub-module: w_rd_fifo (2-entry synchronous FIFO with push/pop/full/empty; asynchronous active-low reset).

Test Plan:
- Model memory with mem[i]=16'h1000+i, numWeight=10, w_ready=1, start pulse in cycle 0:
  - w_valid cycles 3..12 with data 16'h1000..16'h1009.
  - w_last only with 16'h1009.
  - done=1 in cycle 13; busy cycles 1..13 low after.
- Same setup, w_ready toggling 1,0,1,0:
  - Data order and values are unchanged.
  - w_data stable during stalls.
  - At most 2 reads are ahead of the consumer.
  - No FIFO overflow assertion fires.
- w_ready=0 for 20 cycles after start: exactly 2 mem_ren pulses (addresses 0, 1), then mem_ren=0 until w_ready rises.
- start re-pulsed in cycle 5 of a pass: ignored; exactly 10 weights and one done pulse. A second start after done gives an identical second pass.
- rst_n asserted in cycle 6 mid-pass:
  - All outputs 0 immediately (asynchronously).
  - No done pulse.
  - After release, a start gives a full clean pass from address 0.
- numWeight=1 build: single w_valid with w_last=1 and data mem[0]; done follows one cycle after the handshake.
